// File: rtl/period_wave_pkg.sv
// Shared types and default constants for the period-driven square-wave generator.
package period_wave_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned PERIOD_W       = 28;
  localparam int unsigned MIN_PERIOD_DEF = 2;
  localparam int unsigned TICK_CNT_W_DEF = 16;

endpackage

// File: rtl/event_counter.sv
// Wrapping up-counter with synchronous clear and increment; clear has priority.
module event_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + One;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/period_wave_gen.sv
// Square-wave generator driven by a period word; period and stop changes apply only at
// period boundaries so the output never has a runt half-cycle.
module period_wave_gen
  import period_wave_pkg::*;
#(
  parameter int unsigned WIDTH      = PERIOD_W,
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int unsigned TICK_CNT_W = TICK_CNT_W_DEF
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [WIDTH-1:0]      period_in,
  input  logic                  enable,
  input  logic                  tick_clr,
  output logic                  wave_out,
  output logic                  tick_out,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  busy,
  output logic [WIDTH-1:0]      period_active
);

  localparam logic [WIDTH-1:0] MinP   = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_req_q;
  logic [WIDTH-1:0] period_active_q, period_active_d;
  logic             wave_q, wave_d;
  logic             req_ok;
  logic             tick;

  assign req_ok = enable && (period_req_q >= MinP);
  assign tick   = (state_q == RUN) && (cnt_q == '0);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    period_active_d = period_active_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_ok) begin
          state_d         = RUN;
          period_active_d = period_req_q;
          cnt_d           = period_req_q - CntOne;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (req_ok) begin
            period_active_d = period_req_q;
            cnt_d           = period_req_q - CntOne;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Decoded from next-state so the registered wave lines up with cnt in every cycle.
    wave_d = (state_d == RUN) && (cnt_d >= (period_active_d >> 1));
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      period_req_q    <= '0;
      period_active_q <= '0;
      wave_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      period_req_q    <= period_in;
      period_active_q <= period_active_d;
      wave_q          <= wave_d;
    end
  end

  event_counter #(
    .W (TICK_CNT_W)
  ) u_tick_counter (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .clr   (tick_clr),
    .inc   (tick),
    .count (tick_count)
  );

  assign wave_out      = wave_q;
  assign tick_out      = tick;
  assign busy          = (state_q == RUN);
  assign period_active = period_active_q;

endmodule

// File: doc/period_wave_gen.md
Name: period_wave_gen

Overview:
Consumes the 28-bit period word exported by the Nios II system (period0 export) and produces a glitch-free square wave, a one-cycle end-of-period tick and a running tick count.
Sits directly downstream of the processor system in the DE1 top level; wave_out drives an LED or buzzer pin.
Period changes and stop requests take effect only at a period boundary, so the output never has a truncated or runt half-cycle.

Parameters:
WIDTH, 28, width of the period word, in clk_clk cycles.
MIN_PERIOD, 2, smallest period that runs; smaller values, including 0, mean stop.
TICK_CNT_W, 16, width of the tick counter.

Ports:
clk_clk  in  1  system clock, same clock as the processor system.
reset_reset  in  1  synchronous, active-high reset.
period_in  in  WIDTH  requested period, from period0_external_connection_export.
enable  in  1  run request, level-sensitive.
tick_clr  in  1  synchronous clear of tick_count.
wave_out  out  1  registered square wave.
tick_out  out  1  one-cycle pulse in the last cycle of each period.
tick_count  out  TICK_CNT_W  number of completed periods, wraps.
busy  out  1  high while in RUN.
period_active  out  WIDTH  period currently being generated.

Behaviour:
- Reset (synchronous, active-high):
  - Takes effect at the next clk_clk edge, including mid-period.
  - Clears state to IDLE and clears cnt, period_req, period_active, wave_out and tick_count.
  - All outputs are 0 in the cycle after reset is sampled.
- Input registering: period_in is registered into period_req every cycle (1-cycle latency). enable and tick_clr are used directly.
- Counter: cnt is WIDTH bits and counts down.
- State IDLE:
  - cnt=0, wave_out=0, busy=0, tick_out=0.
  - If enable=1 and period_req>=MIN_PERIOD at an edge: go to RUN, load period_active=period_req and cnt=period_req-1.
  - Otherwise stay in IDLE.
- State RUN:
  - cnt decrements by 1 per cycle.
  - tick_out = (state==RUN && cnt==0). This is a pure decode of flops.
  - At the edge where cnt==0:
    - tick_count increments, with wrap from 2^TICK_CNT_W-1 to 0.
    - If enable=1 and period_req>=MIN_PERIOD: reload period_active=period_req and cnt=period_req-1, and stay in RUN.
    - Otherwise go to IDLE.
- wave_out waveform:
  - Registered, and equal to (RUN && cnt >= floor(period_active/2)) in every cycle.
  - For period P: high for ceil(P/2) cycles, then low for floor(P/2) cycles.
  - The first cycle in RUN has wave_out=1.
- Latency: period_in valid at edge k with enable=1 in IDLE gives the first wave_out high in the cycle after edge k+2.
- Boundary conditions:
  - period_in changed mid-period: the current period completes unchanged. period_active updates only at a reload.
  - enable deasserted mid-period: the current period completes, its tick fires, then the block enters IDLE.
  - period_req<MIN_PERIOD at a boundary: handled as a stop, the same as enable=0.
  - tick_clr coincident with a tick: clear wins and tick_count=0.
  - tick_clr in any other cycle: tick_count=0 at the next edge.
  - Maximum period 2^WIDTH-1: no overflow, because cnt loads P-1.
  - busy == (state==RUN).

Decomposition:
- Package period_wave_pkg holds:
  - state enum {IDLE, RUN};
  - default constants PERIOD_W=28, MIN_PERIOD_DEF=2, TICK_CNT_W_DEF=16.
- One sub-module is natural: event_counter, a wrapping up-counter with synchronous clear and increment, clear having priority. It is used for tick_count.
- The FSM, cnt and the wave logic stay in the top module.

Test Plan:
1. Assert reset_reset for 2 cycles with enable=1 and period_in=4 -> all outputs 0 during reset and 0 in the cycle after.
2. period_in=4, enable=1 from IDLE -> wave_out repeats 1,1,0,0; tick_out high on every 4th cycle, coincident with the second low cycle; tick_count reads 1,2,3 after 3 periods; busy=1.
3. period_in=5 -> wave_out high for 3 cycles and low for 2; tick period 5.
4. Running at P=4, change period_in to 6 during the second cycle of a period -> that period still lasts 4 cycles; the following periods are 6 cycles (3 high, 3 low); period_active changes to 6 only at the reload edge.
5. Running at P=4:
   - drop enable mid-period -> the period completes, a tick fires, tick_count increments, then busy=0 and wave_out=0.
   - repeat with period_in=1 and enable held high -> same stop behaviour.
   - period_in=0 from IDLE -> the block never starts.
6. TICK_CNT_W=4, P=2:
   - run 16 periods -> tick_count wraps from 15 to 0.
   - assert tick_clr in the same cycle as tick_out=1 -> tick_count=0.
   - assert reset mid-period -> IDLE with all zeros next cycle.
